// File: rtl/qr_skew_feeder_if.sv
// Row handshake and skewed output bus of the QR skew feeder.
// master: row producer / array-side observer; slave: the feeder itself.
interface qr_skew_feeder_if #(
  parameter int unsigned W = 20
);
  logic         i_valid;
  logic         o_ready;
  logic         i_last;
  logic [W-1:0] i_data_1;
  logic [W-1:0] i_data_2;
  logic [W-1:0] i_data_3;
  logic [W-1:0] i_data_4;
  logic         o_valid;
  logic         o_vectoring_mode;
  logic [W-1:0] o_data_1;
  logic [W-1:0] o_data_2;
  logic [W-1:0] o_data_3;
  logic [W-1:0] o_data_4;
  logic         o_frame_err;

  modport master (
    output i_valid, i_last, i_data_1, i_data_2, i_data_3, i_data_4,
    input  o_ready, o_valid, o_vectoring_mode, o_data_1, o_data_2, o_data_3, o_data_4,
    input  o_frame_err
  );

  modport slave (
    input  i_valid, i_last, i_data_1, i_data_2, i_data_3, i_data_4,
    output o_ready, o_valid, o_vectoring_mode, o_data_1, o_data_2, o_data_3, o_data_4,
    output o_frame_err
  );
endinterface

// File: rtl/qr_skew_feeder.sv
// Input sequencer for the 4-lane CORDIC QR systolic array.
// Buffers whole frames of N_ROWS rows in a 2*N_ROWS row FIFO, then streams each frame
// gap-free to the array with lane 3 delayed SKEW and lane 4 delayed 2*SKEW cycles.
// Optional feature: define QR_FEEDER_FRAME_CHK_EN to enable the sticky i_last framing check.
// SKEW must be at least 1.
module qr_skew_feeder #(
  parameter int unsigned C_IWL  = 5,
  parameter int unsigned C_FWL  = 15,
  parameter int unsigned SKEW   = 4,
  parameter int unsigned N_ROWS = 8,
  parameter int unsigned N_VEC  = 4
) (
  input logic          Clk,
  input logic          Reset,
  qr_skew_feeder_if.slave bus
);
  localparam int unsigned W     = C_IWL + C_FWL;
  localparam int unsigned Depth = 2 * N_ROWS;
  localparam int unsigned PW    = $clog2(Depth);
  localparam int unsigned CW    = $clog2(Depth + 1);
  localparam int unsigned RW    = $clog2(N_ROWS);
  // Lane 3/4 pipelines include the entry stage shared in timing with lane 1/2.
  localparam int unsigned L3    = SKEW + 1;
  localparam int unsigned L4    = 2 * SKEW + 1;

  localparam logic [RW-1:0] LastRow = RW'(N_ROWS - 1);
  localparam logic [PW-1:0] LastPtr = PW'(Depth - 1);
  localparam logic [CW-1:0] FullCnt = CW'(Depth);

  typedef enum logic [0:0] {StIdle, StSend} state_e;
  typedef logic [4*W-1:0] row_t;

  row_t          mem_q [Depth];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] in_row_q, in_row_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [1:0]    frames_q, frames_d;
  state_e        state_q, state_d;

  logic          push, pop, frame_done, frame_take;
  row_t          in_data, head;

  logic          valid_q, valid_d;
  logic          mode_q, mode_d;
  logic [W-1:0]  lane1_q, lane1_d;
  logic [W-1:0]  lane2_q, lane2_d;
  logic [W-1:0]  lane3_q [L3];
  logic [W-1:0]  lane3_d [L3];
  logic [W-1:0]  lane4_q [L4];
  logic [W-1:0]  lane4_d [L4];

  assign bus.o_ready = (count_q != FullCnt);
  assign push        = bus.i_valid && bus.o_ready;
  assign in_data     = {bus.i_data_4, bus.i_data_3, bus.i_data_2, bus.i_data_1};
  assign head        = mem_q[rd_ptr_q];
  assign frame_done  = push && (in_row_q == LastRow);

  // FIFO pointer and occupancy next-state; a pop is only issued while a full frame is held.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Input row counter: frame boundaries come from the count, never from i_last.
  always_comb begin
    in_row_d = in_row_q;
    if (push) begin
      in_row_d = (in_row_q == LastRow) ? '0 : in_row_q + 1'b1;
    end
  end

  // Send FSM: a frame is only started once fully buffered, so emission never bubbles.
  always_comb begin
    state_d    = state_q;
    out_row_d  = out_row_q;
    frame_take = 1'b0;
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        if (frames_q != 2'd0) begin
          state_d    = StSend;
          out_row_d  = '0;
          frame_take = 1'b1;
        end
      end
      StSend: begin
        pop = 1'b1;
        if (out_row_q == LastRow) begin
          out_row_d = '0;
          // A frame completing on this very cycle still chains without a gap.
          if ((frames_q != 2'd0) || frame_done) begin
            frame_take = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          out_row_d = out_row_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    frames_d = frames_q + {1'b0, frame_done} - {1'b0, frame_take};
  end

  // Output stage and skew delay lines; zeros are shifted in while idle.
  always_comb begin
    valid_d    = pop;
    mode_d     = pop && (32'(out_row_q) < N_VEC);
    lane1_d    = pop ? head[W-1:0]     : '0;
    lane2_d    = pop ? head[2*W-1:W]   : '0;
    lane3_d[0] = pop ? head[3*W-1:2*W] : '0;
    lane4_d[0] = pop ? head[4*W-1:3*W] : '0;
    for (int i = 1; i < int'(L3); i++) begin
      lane3_d[i] = lane3_q[i-1];
    end
    for (int i = 1; i < int'(L4); i++) begin
      lane4_d[i] = lane4_q[i-1];
    end
  end

  // Row storage; contents need no reset since the pointers define what is valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Control and datapath state with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      in_row_q  <= '0;
      out_row_q <= '0;
      frames_q  <= '0;
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      mode_q    <= 1'b0;
      lane1_q   <= '0;
      lane2_q   <= '0;
      for (int i = 0; i < int'(L3); i++) begin
        lane3_q[i] <= '0;
      end
      for (int i = 0; i < int'(L4); i++) begin
        lane4_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      in_row_q  <= in_row_d;
      out_row_q <= out_row_d;
      frames_q  <= frames_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      mode_q    <= mode_d;
      lane1_q   <= lane1_d;
      lane2_q   <= lane2_d;
      for (int i = 0; i < int'(L3); i++) begin
        lane3_q[i] <= lane3_d[i];
      end
      for (int i = 0; i < int'(L4); i++) begin
        lane4_q[i] <= lane4_d[i];
      end
    end
  end

  assign bus.o_valid          = valid_q;
  assign bus.o_vectoring_mode = mode_q;
  assign bus.o_data_1         = lane1_q;
  assign bus.o_data_2         = lane2_q;
  assign bus.o_data_3         = lane3_q[L3-1];
  assign bus.o_data_4         = lane4_q[L4-1];

`ifdef QR_FEEDER_FRAME_CHK_EN
  logic frame_err_q, frame_err_d;

  // Sticky flag: i_last must mark exactly the row that closes a frame.
  always_comb begin
    frame_err_d = frame_err_q;
    if (push && (bus.i_last != (in_row_q == LastRow))) begin
      frame_err_d = 1'b1;
    end
  end

  // Framing error register, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.o_frame_err = frame_err_q;
`else
  logic unused_last;
  assign unused_last     = bus.i_last;
  assign bus.o_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_qr_skew_feeder.sv
// Self-checking bench for qr_skew_feeder with a frame-schedule reference model.
module tb_qr_skew_feeder;
  localparam int W      = 20;
  localparam int SKEW   = 4;
  localparam int N_ROWS = 8;
  localparam int N_VEC  = 4;
  localparam int Depth  = 2 * N_ROWS;
  localparam int VW     = 4 + 4 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qr_skew_feeder_if #(.W(W)) bus ();

  qr_skew_feeder #(
    .C_IWL (5),
    .C_FWL (15),
    .SKEW  (SKEW),
    .N_ROWS(N_ROWS),
    .N_VEC (N_VEC)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [VW-1:0] obs_vec;
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] rst_vec;
  assign obs_vec = {bus.o_valid, bus.o_vectoring_mode, bus.o_ready, bus.o_frame_err,
                    bus.o_data_1, bus.o_data_2, bus.o_data_3, bus.o_data_4};

  // Reference model: each completed frame is scheduled as a block of N_ROWS output cycles.
  // It starts 2 cycles after its completing accept, or right after the previous frame when
  // that frame is still sending (chaining).
  logic [4*W-1:0] exp_row [int];
  bit             exp_md  [int];
  logic [4*W-1:0] row_buf [$];
  logic [4*W-1:0] cur, c3, c4;
  int  occ = 0, m_in_row = 0, prev_s = 0, s;
  bit  have_prev = 0, m_err = 0, acc, e_valid, e_mode;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      occ = 0; m_in_row = 0; have_prev = 0; m_err = 0;
      exp_row.delete(); exp_md.delete(); row_buf.delete();
    end else begin
      acc = bus.i_valid && (occ < Depth);
      if (exp_row.exists(cyc)) occ--;
      if (acc) begin
        occ++;
`ifdef QR_FEEDER_FRAME_CHK_EN
        if (bus.i_last != (m_in_row == N_ROWS - 1)) m_err = 1;
`endif
        row_buf.push_back({bus.i_data_4, bus.i_data_3, bus.i_data_2, bus.i_data_1});
        if (m_in_row == N_ROWS - 1) begin
          s = (have_prev && cyc <= prev_s + N_ROWS - 1) ? prev_s + N_ROWS : cyc + 2;
          for (int r = 0; r < N_ROWS; r++) begin
            exp_row[s + r] = row_buf[r];
            exp_md[s + r]  = (r < N_VEC);
          end
          row_buf.delete();
          prev_s = s; have_prev = 1; m_in_row = 0;
        end else begin
          m_in_row++;
        end
      end
    end
    e_valid = exp_row.exists(cyc);
    cur     = e_valid ? exp_row[cyc] : '0;
    e_mode  = e_valid ? exp_md[cyc] : 1'b0;
    c3      = exp_row.exists(cyc - SKEW) ? exp_row[cyc - SKEW] : '0;
    c4      = exp_row.exists(cyc - 2 * SKEW) ? exp_row[cyc - 2 * SKEW] : '0;
    exp_vec = {e_valid, e_mode, (occ < Depth), m_err,
               cur[W-1:0], cur[2*W-1:W], c3[3*W-1:2*W], c4[4*W-1:3*W]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4*W-1:0] row, input logic last);
    bus.i_valid  = v;
    bus.i_data_1 = row[W-1:0];
    bus.i_data_2 = row[2*W-1:W];
    bus.i_data_3 = row[3*W-1:2*W];
    bus.i_data_4 = row[4*W-1:3*W];
    bus.i_last   = last;
  endtask

  function automatic logic [4*W-1:0] rand_row();
    return {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
  endfunction

  task automatic do_reset();
    drive(1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs_vec !== rst_vec)
      $display("FAIL reset_state got=%h want=%h", obs_vec, rst_vec);
    if (obs_vec !== rst_vec) n_fail++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single_frame();
    int t, k, nv;
    logic [4*W-1:0] row;
    do_reset();
    for (int r = 0; r < N_ROWS; r++) begin
      row = {W'(16 * r + 4), W'(16 * r + 3), W'(16 * r + 2), W'(16 * r + 1)};
      drive(1'b1, row, r == N_ROWS - 1);
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL single_push cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
    end
    t = cyc;
    drive(1'b0, '0, 1'b0);
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL single_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      if (bus.o_valid) nv++;
      k = cyc - (t + 2);
      if (k >= 0 && k < N_ROWS) begin
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data_1 !== W'(16 * k + 1) ||
            bus.o_vectoring_mode !== (k < N_VEC)) begin
          n_fail++;
          $display("FAIL single_lane1 row=%0d got v=%b d1=%0d m=%b want d1=%0d m=%b", k,
                   bus.o_valid, bus.o_data_1, bus.o_vectoring_mode, 16 * k + 1, k < N_VEC);
        end
      end
      k = cyc - (t + 2 + SKEW);
      if (k >= 0 && k < N_ROWS) begin
        n_checks++;
        if (bus.o_data_3 !== W'(16 * k + 3)) begin
          n_fail++;
          $display("FAIL single_lane3 row=%0d got=%0d want=%0d", k, bus.o_data_3, 16 * k + 3);
        end
      end
      k = cyc - (t + 2 + 2 * SKEW);
      if (k >= 0 && k < N_ROWS) begin
        n_checks++;
        if (bus.o_data_4 !== W'(16 * k + 4)) begin
          n_fail++;
          $display("FAIL single_lane4 row=%0d got=%0d want=%0d", k, bus.o_data_4, 16 * k + 4);
        end
      end
    end
    n_checks++;
    if (nv != N_ROWS) begin
      n_fail++;
      $display("FAIL single_count got=%0d want=%0d", nv, N_ROWS);
    end
  endtask

  task automatic test_back_to_back();
    int run, max_run, j;
    do_reset();
    run = 0; max_run = 0; j = 0;
    for (int i = 0; i < 60; i++) begin
      drive(i < 2 * N_ROWS, rand_row(), (i % N_ROWS) == N_ROWS - 1);
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL b2b_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      if (bus.o_valid) begin
        run++;
        n_checks++;
        if (bus.o_vectoring_mode !== ((j % N_ROWS) < N_VEC)) begin
          n_fail++;
          $display("FAIL b2b_mode idx=%0d got=%b want=%b", j, bus.o_vectoring_mode,
                   (j % N_ROWS) < N_VEC);
        end
        j++;
      end else begin
        run = 0;
      end
      if (run > max_run) max_run = run;
    end
    n_checks++;
    if (max_run != 2 * N_ROWS) begin
      n_fail++;
      $display("FAIL b2b_run got=%0d want=%0d", max_run, 2 * N_ROWS);
    end
  endtask

  task automatic test_backpressure();
    int nv;
    logic [4*W-1:0] row17, row;
    do_reset();
    nv = 0;
    row17 = rand_row();
    for (int i = 0; i < 2 * N_ROWS + N_ROWS + 40; i++) begin
      row = (i == 2 * N_ROWS) ? row17 : rand_row();
      // 17 rows back to back, a pause, then the rest of the third frame.
      drive(i <= 2 * N_ROWS || (i >= 40 && i < 47), row,
            (i == 2 * N_ROWS - 1) || (i == N_ROWS - 1) || (i == 46));
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL bp_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      if (bus.o_valid) begin
        if (nv == 2 * N_ROWS) begin
          n_checks++;
          if (bus.o_data_1 !== row17[W-1:0]) begin
            n_fail++;
            $display("FAIL bp_row17 got=%h want=%h", bus.o_data_1, row17[W-1:0]);
          end
        end
        nv++;
      end
    end
    n_checks++;
    if (nv != 3 * N_ROWS) begin
      n_fail++;
      $display("FAIL bp_count got=%0d want=%0d", nv, 3 * N_ROWS);
    end
  endtask

  task automatic test_partial_frame();
    int pushed, nv;
    bit v;
    do_reset();
    pushed = 0; nv = 0;
    for (int i = 0; i < 40; i++) begin
      v = (pushed < 5) && ($urandom_range(0, 2) != 0);
      drive(v, rand_row(), 1'b0);
      tick();
      if (v) pushed++;
      n_checks++;
      if (bus.o_valid !== 1'b0 || obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL partial_hold cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
    end
    for (int i = 0; i < 40; i++) begin
      v = (pushed < N_ROWS);
      drive(v, rand_row(), pushed == N_ROWS - 1);
      tick();
      if (v) pushed++;
      if (bus.o_valid) nv++;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL partial_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (nv != N_ROWS) begin
      n_fail++;
      $display("FAIL partial_count got=%0d want=%0d", nv, N_ROWS);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [4*W-1:0] rows [N_ROWS];
    int guard;
    do_reset();
    for (int r = 0; r < N_ROWS; r++) begin
      rows[r] = rand_row();
      drive(1'b1, rows[r], r == N_ROWS - 1);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    guard = 0;
    while (!bus.o_valid && guard < 10) begin
      tick();
      guard++;
    end
    n_checks++;
    if (bus.o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_start got=%b want=1", bus.o_valid);
    end
    tick();
    tick();
    n_checks++;
    if (bus.o_data_1 !== rows[2][W-1:0]) begin
      n_fail++;
      $display("FAIL midrst_row2 got=%h want=%h", bus.o_data_1, rows[2][W-1:0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs_vec !== rst_vec) begin
      n_fail++;
      $display("FAIL midrst_clear got=%h want=%h", obs_vec, rst_vec);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (obs_vec !== rst_vec || obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL midrst_stale cyc=%0d got=%h want=%h", cyc, obs_vec, rst_vec);
      end
    end
  endtask

  task automatic test_random();
    int pushed, nv;
    bit v;
    do_reset();
    pushed = 0; nv = 0;
    for (int i = 0; i < 150; i++) begin
      v = (pushed < 3 * N_ROWS) && ($urandom_range(0, 3) != 0);
      drive(v, rand_row(), (pushed % N_ROWS) == N_ROWS - 1);
      tick();
      if (v) pushed++;
      if (bus.o_valid) nv++;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (nv != 3 * N_ROWS) begin
      n_fail++;
      $display("FAIL random_count got=%0d want=%0d", nv, 3 * N_ROWS);
    end
  endtask

`ifdef QR_FEEDER_FRAME_CHK_EN
  task automatic test_frame_err();
    int nv;
    do_reset();
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      drive(i < N_ROWS, rand_row(), i == 5);
      tick();
      if (bus.o_valid) nv++;
      n_checks++;
      if (bus.o_frame_err !== (i >= 5) || obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL frame_err cyc=%0d got err=%b vec=%h want err=%b vec=%h", cyc,
                 bus.o_frame_err, obs_vec, i >= 5, exp_vec);
      end
    end
    n_checks++;
    if (nv != N_ROWS) begin
      n_fail++;
      $display("FAIL frame_err_count got=%0d want=%0d", nv, N_ROWS);
    end
    do_reset();
    #1;
    n_checks++;
    if (bus.o_frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_err_clear got=%b want=0", bus.o_frame_err);
    end
  endtask
`endif

  initial begin
    rst_vec = '0;
    rst_vec[VW-3] = 1'b1;
    drive(1'b0, '0, 1'b0);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_partial_frame();
    test_reset_mid_send();
    test_random();
`ifdef QR_FEEDER_FRAME_CHK_EN
    test_frame_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
